// File: rtl/planning_controller.sv
// Shadow-tracking planner for the robot/obstacle grid plant: mirrors both
// positions cycle-exactly and steers the robot toward the goal cell safely.
module planning_controller #(
    parameter int K          = 3,
    parameter int W          = 4,
    parameter int GOAL_X     = 8,
    parameter int GOAL_Y     = 8,
    parameter int OBS_INIT_X = 2,
    parameter int SAFE_DIST  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_obs1_up,
    input  logic       move_obs1_down,
    input  logic       move_obs1_left,
    input  logic       move_obs1_right,
    input  logic       _rt_robot,
    input  logic       error,
    output logic       move_robot,
    output logic       controllable_up,
    output logic       controllable_down,
    output logic       controllable_left,
    output logic       controllable_right,
    output logic       at_goal,
    output logic       stuck,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_PLAN = 3'd1,
        S_DONE = 3'd2,
        S_HALT = 3'd3
    } state_e;

    localparam int           GMAX   = 3 * K - 1;
    localparam logic [W-1:0] GMAX_W = W'(3 * K - 1);
    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] OBS_X0 = W'(OBS_INIT_X);

    state_e       state_q, state_d;
    logic [W-1:0] rx_q, rx_d, ry_q, ry_d;
    logic [W-1:0] ox_q, ox_d, oy_q, oy_d;

    // Direction codes: 0 down, 1 up, 2 left, 3 right
    function automatic logic safe_f(input logic [1:0] d, input int rx,
                                    input int ry, input int ox, input int oy);
        int nx, ny, ax, ay;
        nx = rx;
        ny = ry;
        case (d)
            2'd0:    ny = ry - 1;
            2'd1:    ny = ry + 1;
            2'd2:    nx = rx - 1;
            default: nx = rx + 1;
        endcase
        ax = (nx > ox) ? nx - ox : ox - nx;
        ay = (ny > oy) ? ny - oy : oy - ny;
        return (nx >= 0) && (nx <= GMAX) && (ny >= 0) && (ny <= GMAX) &&
               ((ax >= SAFE_DIST) || (ay >= SAFE_DIST));
    endfunction

    int         dx, dy, adx, ady;
    logic       goal_hit, found;
    logic [1:0] dir, xdir, ydir;
    logic [1:0] cand   [6];
    logic       cand_v [6];

    always_comb begin
        dx       = GOAL_X - int'(rx_q);
        dy       = GOAL_Y - int'(ry_q);
        adx      = (dx < 0) ? -dx : dx;
        ady      = (dy < 0) ? -dy : dy;
        goal_hit = (dx == 0) && (dy == 0);
        xdir     = (dx > 0) ? 2'd3 : 2'd2;
        ydir     = (dy > 0) ? 2'd1 : 2'd0;
        cand[0]   = (adx >= ady) ? xdir : ydir;
        cand_v[0] = 1'b1;
        cand[1]   = (adx >= ady) ? ydir : xdir;
        cand_v[1] = (adx >= ady) ? (dy != 0) : (dx != 0);
        cand[2]   = 2'd0;
        cand[3]   = 2'd1;
        cand[4]   = 2'd2;
        cand[5]   = 2'd3;
        cand_v[2] = 1'b1;
        cand_v[3] = 1'b1;
        cand_v[4] = 1'b1;
        cand_v[5] = 1'b1;
        found = 1'b0;
        dir   = 2'd0;
        for (int i = 0; i < 6; i++) begin
            if (!found && cand_v[i] &&
                safe_f(cand[i], int'(rx_q), int'(ry_q), int'(ox_q), int'(oy_q))) begin
                found = 1'b1;
                dir   = cand[i];
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        move_robot         = 1'b0;
        controllable_up    = 1'b0;
        controllable_down  = 1'b0;
        controllable_left  = 1'b0;
        controllable_right = 1'b0;
        at_goal            = 1'b0;
        stuck              = 1'b0;
        state              = state_q;
        unique case (state_q)
            S_INIT: state_d = S_PLAN;
            S_PLAN: begin
                if (goal_hit) begin
                    at_goal = 1'b1;
                    state_d = S_DONE;
                end else if (found) begin
                    move_robot         = 1'b1;
                    controllable_down  = (dir == 2'd0);
                    controllable_up    = (dir == 2'd1);
                    controllable_left  = (dir == 2'd2);
                    controllable_right = (dir == 2'd3);
                end else begin
                    stuck = 1'b1;
                end
                if (error) state_d = S_HALT;
            end
            S_DONE: begin
                at_goal = goal_hit;
                if (!goal_hit) state_d = S_PLAN;
                if (error) state_d = S_HALT;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        rx_d = rx_q;
        ry_d = ry_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (state_q == S_INIT) ox_d = OBS_X0;
        // Obstacle mirrors the plant's clamping; up beats down, left beats right
        if (state_q == S_PLAN || state_q == S_DONE) begin
            if (move_obs1_up && oy_q < GMAX_W) oy_d = oy_q + ONE;
            else if (move_obs1_down && oy_q != '0) oy_d = oy_q - ONE;
            if (move_obs1_left && ox_q != '0) ox_d = ox_q - ONE;
            else if (move_obs1_right && ox_q < GMAX_W) ox_d = ox_q + ONE;
        end
        if (_rt_robot) begin
            if (controllable_up && ry_q < GMAX_W) ry_d = ry_q + ONE;
            if (controllable_down && ry_q != '0) ry_d = ry_q - ONE;
            if (controllable_left && rx_q != '0) rx_d = rx_q - ONE;
            if (controllable_right && rx_q < GMAX_W) rx_d = rx_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            rx_q    <= '0;
            ry_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

endmodule
